// File: rtl/core_mem_if.sv
// ============================================================================
// Module   : core_mem_if
// Summary  : EX/MEM input stream, data bus and MEM/WB output stream of core_mem.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface core_mem_if;
   logic        em_valid;
   logic        em_ready;
   logic [31:0] em_reg_data_mem_addr;
   logic [31:0] em_csr_data_mem_data;
   logic        em_mem_read;
   logic        em_mem_write;
   logic [2:0]  em_mem_op_type;
   logic [4:0]  em_rd;
   logic        em_reg_write;
   logic [11:0] em_csr;
   logic        em_csr_write;

   logic        bus_read;
   logic        bus_write;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_byte_en;
   logic        bus_ready;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;

   logic        mw_valid;
   logic        mw_ready;
   logic [31:0] mw_reg_data;
   logic [4:0]  mw_rd;
   logic        mw_reg_write;
   logic [11:0] mw_csr;
   logic [31:0] mw_csr_data;
   logic        mw_csr_write;
   logic        mw_exception;
   logic [31:0] mw_exception_cause;
   logic [31:0] mw_bad_addr;

   // Stage side: consumes EX/MEM, masters the data bus, produces MEM/WB.
   modport slave (
      input  em_valid, em_reg_data_mem_addr, em_csr_data_mem_data, em_mem_read,
             em_mem_write, em_mem_op_type, em_rd, em_reg_write, em_csr, em_csr_write,
             bus_ready, bus_rvalid, bus_rdata, mw_ready,
      output em_ready, bus_read, bus_write, bus_addr, bus_wdata, bus_byte_en,
             mw_valid, mw_reg_data, mw_rd, mw_reg_write, mw_csr, mw_csr_data,
             mw_csr_write, mw_exception, mw_exception_cause, mw_bad_addr
   );

   modport master (
      output em_valid, em_reg_data_mem_addr, em_csr_data_mem_data, em_mem_read,
             em_mem_write, em_mem_op_type, em_rd, em_reg_write, em_csr, em_csr_write,
             bus_ready, bus_rvalid, bus_rdata, mw_ready,
      input  em_ready, bus_read, bus_write, bus_addr, bus_wdata, bus_byte_en,
             mw_valid, mw_reg_data, mw_rd, mw_reg_write, mw_csr, mw_csr_data,
             mw_csr_write, mw_exception, mw_exception_cause, mw_bad_addr
   );
endinterface

`default_nettype wire

// File: rtl/core_mem.sv
// ============================================================================
// Module   : core_mem
// Summary  : Memory-access pipeline stage with single-outstanding data bus.
//            Optional misalignment trap: define CORE_MEM_MISALIGN_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_mem #(
   parameter int unsigned BUS_TIMEOUT = 256
) (
   input  logic      clk,
   input  logic      rest,
   core_mem_if.slave mem_if
);

   localparam int unsigned CW      = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;
   localparam int unsigned TO_LAST = (BUS_TIMEOUT == 0) ? 0 : BUS_TIMEOUT - 1;
   localparam logic [CW-1:0] C_TO_LAST = CW'(TO_LAST);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2,
      ST_OUT  = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [2:0]  op_q, op_d;
   logic        read_q, read_d;
   logic        write_q, write_d;
   logic [4:0]  rd_q, rd_d;
   logic        reg_write_q, reg_write_d;
   logic [11:0] csr_q, csr_d;
   logic        csr_write_q, csr_write_d;
   logic [31:0] reg_data_q, reg_data_d;
   logic        exc_q, exc_d;
   logic [31:0] cause_q, cause_d;
   logic [31:0] bad_addr_q, bad_addr_d;

   logic        em_ready;
   logic        accept;
   logic        expire;
   logic        in_req;
   logic        is_mem;
   logic        misaligned;

   function automatic logic [31:0] load_extract(input logic [2:0]  op,
                                                input logic [1:0]  a,
                                                input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = 8'(d >> {a, 3'b000});
      h = a[1] ? d[31:16] : d[15:0];
      case (op)
         3'b000:  r = {{24{b[7]}}, b};
         3'b100:  r = {24'd0, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b101:  r = {16'd0, h};
         default: r = d;
      endcase
      return r;
   endfunction

   assign em_ready = (state_q == ST_IDLE) || ((state_q == ST_OUT) && mem_if.mw_ready);
   assign accept   = mem_if.em_valid && em_ready;
   assign expire   = (BUS_TIMEOUT != 0) && (cnt_q == C_TO_LAST);
   assign in_req   = (state_q == ST_REQ);
   assign is_mem   = mem_if.em_mem_read || mem_if.em_mem_write;

`ifdef CORE_MEM_MISALIGN_EN
   always_comb begin
      misaligned = 1'b0;
      case (mem_if.em_mem_op_type[1:0])
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = mem_if.em_reg_data_mem_addr[0];
         default: misaligned = |mem_if.em_reg_data_mem_addr[1:0];
      endcase
   end
`else
   assign misaligned = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      data_d      = data_q;
      op_d        = op_q;
      read_d      = read_q;
      write_d     = write_q;
      rd_d        = rd_q;
      reg_write_d = reg_write_q;
      csr_d       = csr_q;
      csr_write_d = csr_write_q;
      reg_data_d  = reg_data_q;
      exc_d       = exc_q;
      cause_d     = cause_q;
      bad_addr_d  = bad_addr_q;

      case (state_q)
         ST_IDLE, ST_OUT: begin
            if (state_q == ST_OUT && mem_if.mw_ready) begin
               state_d = ST_IDLE;
            end
            if (accept) begin
               addr_d      = mem_if.em_reg_data_mem_addr;
               data_d      = mem_if.em_csr_data_mem_data;
               op_d        = mem_if.em_mem_op_type;
               read_d      = mem_if.em_mem_read;
               write_d     = mem_if.em_mem_write && !mem_if.em_mem_read;
               rd_d        = mem_if.em_rd;
               reg_write_d = mem_if.em_reg_write;
               csr_d       = mem_if.em_csr;
               csr_write_d = mem_if.em_csr_write && !mem_if.em_mem_read;
               reg_data_d  = mem_if.em_reg_data_mem_addr;
               exc_d       = 1'b0;
               cause_d     = 32'd0;
               bad_addr_d  = 32'd0;
               state_d     = is_mem ? ST_REQ : ST_OUT;
               // Misaligned accesses trap here and never reach the bus.
               if (is_mem && misaligned) begin
                  state_d     = ST_OUT;
                  exc_d       = 1'b1;
                  cause_d     = mem_if.em_mem_read ? 32'd4 : 32'd6;
                  bad_addr_d  = mem_if.em_reg_data_mem_addr;
                  reg_write_d = 1'b0;
                  csr_write_d = 1'b0;
               end
            end
         end
         ST_REQ, ST_RESP: begin
            if (state_q == ST_REQ && mem_if.bus_ready) begin
               state_d = read_q ? ST_RESP : ST_OUT;
            end else if (state_q == ST_RESP && mem_if.bus_rvalid) begin
               reg_data_d = load_extract(op_q, addr_q[1:0], mem_if.bus_rdata);
               state_d    = ST_OUT;
            end else if (expire) begin
               state_d     = ST_OUT;
               exc_d       = 1'b1;
               cause_d     = read_q ? 32'd5 : 32'd7;
               bad_addr_d  = addr_q;
               reg_write_d = 1'b0;
               csr_write_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (state_q == ST_REQ || state_q == ST_RESP) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         addr_q      <= 32'd0;
         data_q      <= 32'd0;
         op_q        <= 3'd0;
         read_q      <= 1'b0;
         write_q     <= 1'b0;
         rd_q        <= 5'd0;
         reg_write_q <= 1'b0;
         csr_q       <= 12'd0;
         csr_write_q <= 1'b0;
         reg_data_q  <= 32'd0;
         exc_q       <= 1'b0;
         cause_q     <= 32'd0;
         bad_addr_q  <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         op_q        <= op_d;
         read_q      <= read_d;
         write_q     <= write_d;
         rd_q        <= rd_d;
         reg_write_q <= reg_write_d;
         csr_q       <= csr_d;
         csr_write_q <= csr_write_d;
         reg_data_q  <= reg_data_d;
         exc_q       <= exc_d;
         cause_q     <= cause_d;
         bad_addr_q  <= bad_addr_d;
      end
   end

   // Bus fields are zero outside REQ so strobes fall with the async reset.
   logic [3:0]  byte_en;
   logic [31:0] wdata;
   always_comb begin
      byte_en = 4'b1111;
      wdata   = data_q;
      case (op_q[1:0])
         2'b00: begin
            byte_en = 4'b0001 << addr_q[1:0];
            wdata   = {4{data_q[7:0]}};
         end
         2'b01: begin
            byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
            wdata   = {2{data_q[15:0]}};
         end
         default: begin
            byte_en = 4'b1111;
            wdata   = data_q;
         end
      endcase
   end

   assign mem_if.em_ready    = em_ready;
   assign mem_if.bus_read    = in_req && read_q;
   assign mem_if.bus_write   = in_req && write_q;
   assign mem_if.bus_addr    = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
   assign mem_if.bus_wdata   = in_req ? wdata : 32'd0;
   assign mem_if.bus_byte_en = in_req ? byte_en : 4'd0;

   assign mem_if.mw_valid           = (state_q == ST_OUT);
   assign mem_if.mw_reg_data        = reg_data_q;
   assign mem_if.mw_rd              = rd_q;
   assign mem_if.mw_reg_write       = reg_write_q;
   assign mem_if.mw_csr             = csr_q;
   assign mem_if.mw_csr_data        = data_q;
   assign mem_if.mw_csr_write       = csr_write_q;
   assign mem_if.mw_exception       = exc_q;
   assign mem_if.mw_exception_cause = cause_q;
   assign mem_if.mw_bad_addr        = bad_addr_q;

endmodule

`default_nettype wire
